// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built from two half-adder cells and a carry flop.
//
// Accepts an operand pair over a valid/ready handshake, adds one bit per
// clock LSB-first, then presents {carry, sum} over a second valid/ready
// handshake. Accept-to-out_valid latency is exactly WIDTH clocks.
//
// Parameters:
//   WIDTH      operand/sum width in bits (1..64)
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   sub        (SERIAL_ADDER_SUB_EN only) 1 = compute a - b, sampled on accept
//   in_valid   operand pair on a/b is valid
//   in_ready   block can accept an operand pair (IDLE only)
//   a, b       addends, sampled only on the accept edge
//   out_valid  sum/carry valid (DONE only)
//   out_ready  consumer accepts sum/carry
//   sum        WIDTH-bit result
//   carry      carry-out of the MSB (for subtract: 1 = no borrow)
//
// Build option:
//   SERIAL_ADDER_SUB_EN  adds the sub port; subtraction loads ~b and presets
//                        the carry flop to 1 (two's-complement a + ~b + 1).

// One-bit half adder cell.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  // Operand B and carry preset as loaded on the accept edge.
  logic [WIDTH-1:0] b_load_c;
  logic             cy_load_c;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load_c  = sub ? ~b : b;
  assign cy_load_c = sub;
`else
  assign b_load_c  = b;
  assign cy_load_c = 1'b0;
`endif

  // Full adder: two half adders plus an OR on their carries.
  logic ha0_s, ha0_c, ha1_s, ha1_c;
  logic fa_s_c, fa_c_c;

  half_adder u_ha0 (
    .x (sa_q[0]),
    .y (sb_q[0]),
    .s (ha0_s),
    .c (ha0_c)
  );

  half_adder u_ha1 (
    .x (ha0_s),
    .y (cy_q),
    .s (ha1_s),
    .c (ha1_c)
  );

  assign fa_s_c = ha1_s;
  assign fa_c_c = ha0_c | ha1_c;

  // Next-state and register-input logic.
  always_comb begin
    state_d     = state_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    sum_d       = sum_q;
    cy_d        = cy_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d       = a;
          sb_d       = b_load_c;
          sum_d      = '0;
          cy_d       = cy_load_c;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end

      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        // New bit enters at the MSB so the LSB-first stream ends aligned.
        sum_d = WIDTH'({fa_s_c, sum_q} >> 1);
        cy_d  = fa_c_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      sum_q       <= '0;
      cy_q        <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      sum_q       <= sum_d;
      cy_q        <= cy_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry     = cy_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 directed + random ops with backpressure,
// mid-operation reset, and exhaustive WIDTH=4 / WIDTH=1 operand sweeps.
module tb_serial_adder;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       iv8 = 1'b0, ordy8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ir8, ov8, c8;
  logic [7:0] s8;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8 = 1'b0;
`endif

  // WIDTH=4 instance
  logic       iv4 = 1'b0, ordy4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ir4, ov4, c4;
  logic [3:0] s4;

  // WIDTH=1 instance
  logic       iv1 = 1'b0, ordy1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       ir1, ov1, c1;
  logic [0:0] s1;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(ordy8), .sum(s8), .carry(c8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(ordy4), .sum(s4), .carry(c4)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(ordy1), .sum(s1), .carry(c1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {carry,sum} = a + b, or a - b + 2^8 when subtracting.
  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
    int r;
    if (s) r = int'(x) + 256 - int'(y);
    else   r = int'(x) + int'(y);
    return 9'(r);
  endfunction

  // One complete WIDTH=8 transaction with optional output stall.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic ts, input int stall);
    logic [8:0] exp;
    int lat;
    logic bad;
    exp = ref8(ta, tb_, ts);
    @(negedge clk);
    check("in_ready_idle", 64'(ir8), 64'd1);
    a8 = ta; b8 = tb_; iv8 = 1'b1; ordy8 = (stall == 0);
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = ts;
`endif
    @(posedge clk); #1;
    // Operand and in_valid changes after accept must be ignored.
    a8 = 8'($urandom); b8 = 8'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'($urandom);
`endif
    lat = 0; bad = 1'b0;
    while (!ov8 && lat < 200) begin
      if (ir8) bad = 1'b1;
      iv8 = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    iv8 = 1'b0;
    check("latency8", 64'(lat), 64'd8);
    check("sum8", 64'(s8), 64'(exp[7:0]));
    check("carry8", 64'(c8), 64'(exp[8]));
    repeat (stall) begin
      iv8 = 1'($urandom);
      @(posedge clk); #1;
      if (!ov8 || s8 !== exp[7:0] || c8 !== exp[8] || ir8) bad = 1'b1;
    end
    check("busy_hold8", 64'(bad), 64'd0);
    iv8 = 1'b0; ordy8 = 1'b1;
    @(posedge clk); #1;
    check("handshake_ov8", 64'(ov8), 64'd0);
    check("handshake_ir8", 64'(ir8), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ea, eb;
    logic sv;

    // Reset state
    #12;
    check("rst_ir", 64'(ir8), 64'd1);
    check("rst_ov", 64'(ov8), 64'd0);
    check("rst_sum", 64'(s8), 64'd0);
    check("rst_carry", 64'(c8), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases
    op8(8'h0F, 8'h01, 1'b0, 0);
    op8(8'hFF, 8'h01, 1'b0, 0);
    op8(8'hFF, 8'hFF, 1'b0, 0);
    op8(8'h12, 8'h34, 1'b0, 5);
    if (HAS_SUB) begin
      op8(8'h05, 8'h07, 1'b1, 0);
      op8(8'h07, 8'h05, 1'b1, 2);
    end

    // Reset mid-operation, asserted between clock edges
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; iv8 = 1'b1; ordy8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'b0;
`endif
    @(posedge clk); #1; iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_ov", 64'(ov8), 64'd0);
    check("abort_sum", 64'(s8), 64'd0);
    check("abort_carry", 64'(c8), 64'd0);
    check("abort_ir", 64'(ir8), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op8(8'h03, 8'h04, 1'b0, 0);

    // Random operands, random stall
    for (int k = 0; k < 24; k++) begin
      sv = HAS_SUB ? 1'($urandom) : 1'b0;
      op8(8'($urandom), 8'($urandom), sv, int'($urandom_range(0, 3)));
    end

    // Exhaustive WIDTH=4
    ordy4 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ea = i >> 4; eb = i & 15;
      @(negedge clk);
      check("w4_ir", 64'(ir4), 64'd1);
      a4 = 4'(ea); b4 = 4'(eb); iv4 = 1'b1;
      @(posedge clk); #1; iv4 = 1'b0;
      lat = 0;
      while (!ov4 && lat < 50) begin
        @(posedge clk); #1; lat++;
      end
      check("w4_lat", 64'(lat), 64'd4);
      check("w4_result", 64'({c4, s4}), 64'(ea + eb));
      @(posedge clk);
    end

    // Exhaustive WIDTH=1
    ordy1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ea = i >> 1; eb = i & 1;
      @(negedge clk);
      check("w1_ir", 64'(ir1), 64'd1);
      a1 = 1'(ea); b1 = 1'(eb); iv1 = 1'b1;
      @(posedge clk); #1; iv1 = 1'b0;
      lat = 0;
      while (!ov1 && lat < 50) begin
        @(posedge clk); #1; lat++;
      end
      check("w1_lat", 64'(lat), 64'd1);
      check("w1_result", 64'({c1, s1}), 64'(ea + eb));
      @(posedge clk);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
